// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: FSM states and the
// region address map (inclusive base/limit byte addresses).
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } dmem_state_t;

  localparam int MAX_REGIONS = 2;

  // Region 0 is user .data, region 1 is system .kdata
  localparam logic [31:0] REGION_BASE  [MAX_REGIONS] = '{32'h1001_0000, 32'h9000_0000};
  localparam logic [31:0] REGION_LIMIT [MAX_REGIONS] = '{32'h1001_1FFF, 32'h9000_07FF};

  function automatic int region_width(input int nregions);
    return (nregions > 1) ? $clog2(nregions) : 1;
  endfunction

endpackage

// File: rtl/dmem_region_decode.sv
// Combinational region decode and access-fault detection for one request.
// On overlapping regions the lowest index is reported.
module dmem_region_decode
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NREGIONS = 2,
  parameter int REGION_W = 1
) (
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [NREGIONS-1:0] hit,
  output logic [REGION_W-1:0] region,
  output logic                fault
);

  // Compare in 64 bits so the map works for any address width up to 64
  always_comb begin
    hit    = '0;
    region = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      hit[i] = (64'(address) >= 64'(REGION_BASE[i])) &&
               (64'(address) <= 64'(REGION_LIMIT[i]));
    end
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      if (hit[i]) region = REGION_W'(i);
    end
    fault = (hit == '0) || (address[1:0] != 2'b00) || (byte_en == '0);
  end

endmodule

// File: rtl/data_memory_controller.sv
// Single-outstanding-request controller in front of per-region synchronous RAMs
// that share address, byte-enable and write-data buses.
module data_memory_controller
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NREGIONS = 2,
  parameter int RAM_AW   = 11
) (
  input  logic                         iCLK,
  input  logic                         iRST_n,
  input  logic                         iReq,
  input  logic                         iWe,
  input  logic [DATA_W/8-1:0]          iByteEn,
  input  logic [ADDR_W-1:0]            iAddress,
  input  logic [DATA_W-1:0]            iWriteData,
  output logic                         oReady,
  output logic                         oRspValid,
  output logic [DATA_W-1:0]            oReadData,
  output logic                         oFault,
  output logic [7:0]                   oFaultCount,
  output logic [RAM_AW-1:0]            oMemAddr,
  output logic [DATA_W/8-1:0]          oMemByteEn,
  output logic [DATA_W-1:0]            oMemData,
  output logic [NREGIONS-1:0]          oMemWe,
  input  logic [NREGIONS*DATA_W-1:0]   iMemQ
);

  localparam int BE_W     = DATA_W / 8;
  localparam int REGION_W = region_width(NREGIONS);

  dmem_state_t state, next_state;

  logic [RAM_AW-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   data_q;
  logic                we_q;
  logic                fault_q;
  logic [REGION_W-1:0] region_q;
  logic [NREGIONS-1:0] we_sel_q;
  logic [DATA_W-1:0]   read_data_q;
  logic [7:0]          fault_count_q;

  logic [NREGIONS-1:0] dec_hit;
  logic [REGION_W-1:0] dec_region;
  logic                dec_fault;
  logic [NREGIONS-1:0] dec_onehot;
  logic                accept;

  dmem_region_decode #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NREGIONS(NREGIONS),
    .REGION_W(REGION_W)
  ) u_decode (
    .address(iAddress),
    .byte_en(iByteEn),
    .hit    (dec_hit),
    .region (dec_region),
    .fault  (dec_fault)
  );

  assign accept     = (state == ST_IDLE) && iReq;
  // Lowest set hit bit, so overlapping regions still give a one-hot strobe
  assign dec_onehot = dec_hit & (~dec_hit + 1'b1);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (iReq) next_state = dec_fault ? ST_RESP : ST_ISSUE;
      ST_ISSUE: next_state = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_q   <= '0;
      be_q     <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      region_q <= '0;
      we_sel_q <= '0;
    end else if (accept) begin
      addr_q   <= iAddress[RAM_AW+1:2];
      be_q     <= iByteEn;
      data_q   <= iWriteData;
      we_q     <= iWe;
      fault_q  <= dec_fault;
      region_q <= dec_region;
      we_sel_q <= (iWe && !dec_fault) ? dec_onehot : '0;
    end
  end

  // Faults clear the read data at accept so the fault response shows zero
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)                read_data_q <= '0;
    else if (accept && dec_fault) read_data_q <= '0;
    else if (state == ST_WAIT)    read_data_q <= iMemQ[int'(region_q)*DATA_W +: DATA_W];
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)                                           fault_count_q <= '0;
    else if (accept && dec_fault && fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
  end

  assign oReady      = (state == ST_IDLE);
  assign oRspValid   = (state == ST_RESP);
  assign oFault      = (state == ST_RESP) && fault_q;
  assign oReadData   = read_data_q;
  assign oFaultCount = fault_count_q;
  assign oMemAddr    = addr_q;
  assign oMemByteEn  = be_q;
  assign oMemData    = data_q;
  assign oMemWe      = (state == ST_ISSUE) ? we_sel_q : '0;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed self-checking bench for data_memory_controller with a behavioural
// two-region synchronous RAM (read-first, one cycle latency).
module tb_data_memory_controller;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [3:0]  byte_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] read_data;
  logic        fault;
  logic [7:0]  fault_count;
  logic [10:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_data;
  logic [1:0]  mem_we;
  logic [63:0] mem_q;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem0 [0:2047];
  logic [31:0] mem1 [0:2047];
  logic [31:0] q0, q1;

  data_memory_controller dut (
    .iCLK       (clk),
    .iRST_n     (rst_n),
    .iReq       (req),
    .iWe        (we),
    .iByteEn    (byte_en),
    .iAddress   (address),
    .iWriteData (write_data),
    .oReady     (ready),
    .oRspValid  (rsp_valid),
    .oReadData  (read_data),
    .oFault     (fault),
    .oFaultCount(fault_count),
    .oMemAddr   (mem_addr),
    .oMemByteEn (mem_be),
    .oMemData   (mem_data),
    .oMemWe     (mem_we),
    .iMemQ      (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_q = {q1, q0};

  // Region RAMs: byte-lane writes, registered read of the old word
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[0] && mem_be[b]) mem0[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
      if (mem_we[1] && mem_be[b]) mem1[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
    end
    q0 <= mem0[mem_addr];
    q1 <= mem1[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request from an idle negedge; latency k means the response is
  // seen at the k-th negedge after the accepting edge.
  task automatic applyStimulus(input logic s_we, input logic [3:0] s_be, input logic [31:0] s_addr,
                               input logic [31:0] s_wdata, output int lat, output logic [31:0] rdata,
                               output logic flt, output logic [1:0] we_or, output int we_cycles,
                               output logic [10:0] we_addr);
    req = 1'b1; we = s_we; byte_en = s_be; address = s_addr; write_data = s_wdata;
    lat = 0; rdata = 'x; flt = 1'bx; we_or = '0; we_cycles = 0; we_addr = '0;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we != 2'b00) begin
        we_or |= mem_we;
        we_cycles++;
        we_addr = mem_addr;
      end
      if (rsp_valid) begin
        lat = k; rdata = read_data; flt = fault;
        break;
      end
    end
    @(negedge clk);
  endtask

  int          lat, we_cycles, accepts, rsps, n_rsp;
  logic [31:0] rdata;
  logic        flt;
  logic [1:0]  we_or;
  logic [10:0] we_addr;
  logic [7:0]  cnt254;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; byte_en = '0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    checkOutput("reset_read_data", read_data, 32'd0);
    checkOutput("reset_fault_count", 32'(fault_count), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd1);

    // First request goes in on the first edge after reset release
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'hF, 32'h1001_0004, 32'hDEAD_BEEF, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("wr0_latency", 32'(lat), 32'd2);
    checkOutput("wr0_fault", 32'(flt), 32'd0);
    checkOutput("wr0_mem_we", 32'(we_or), 32'h1);
    checkOutput("wr0_we_cycles", 32'(we_cycles), 32'd1);
    checkOutput("wr0_mem_addr", 32'(we_addr), 32'd1);

    applyStimulus(1'b0, 4'hF, 32'h1001_0004, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("rd0_latency", 32'(lat), 32'd3);
    checkOutput("rd0_data", rdata, 32'hDEAD_BEEF);
    checkOutput("rd0_mem_we", 32'(we_or), 32'h0);

    applyStimulus(1'b1, 4'hF, 32'h9000_0010, 32'h1122_3344, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("wr1_latency", 32'(lat), 32'd2);
    checkOutput("wr1_mem_we", 32'(we_or), 32'h2);
    checkOutput("wr1_holds_read_data", rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 4'h1, 32'h9000_0010, 32'h0000_00AA, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("wr2_mem_we", 32'(we_or), 32'h2);
    checkOutput("wr2_mem_addr", 32'(we_addr), 32'd4);

    applyStimulus(1'b0, 4'h1, 32'h9000_0010, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("rd1_latency", 32'(lat), 32'd3);
    checkOutput("rd1_full_word", rdata, 32'h1122_33AA);

    applyStimulus(1'b0, 4'hF, 32'h0040_0000, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("unmapped_latency", 32'(lat), 32'd1);
    checkOutput("unmapped_fault", 32'(flt), 32'd1);
    checkOutput("unmapped_data", rdata, 32'd0);
    checkOutput("unmapped_mem_we", 32'(we_or), 32'h0);

    applyStimulus(1'b1, 4'hF, 32'h1001_0002, 32'hFFFF_FFFF, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("misaligned_latency", 32'(lat), 32'd1);
    checkOutput("misaligned_fault", 32'(flt), 32'd1);
    checkOutput("misaligned_mem_we", 32'(we_or), 32'h0);
    checkOutput("fault_count_2", 32'(fault_count), 32'd2);

    applyStimulus(1'b0, 4'h0, 32'h1001_0004, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("zero_be_fault", 32'(flt), 32'd1);

    applyStimulus(1'b0, 4'hF, 32'h1001_1FFC, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("r0_top_word_latency", 32'(lat), 32'd3);
    checkOutput("r0_top_word_fault", 32'(flt), 32'd0);

    applyStimulus(1'b0, 4'hF, 32'h1001_2000, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("r0_past_limit_fault", 32'(flt), 32'd1);

    applyStimulus(1'b0, 4'hF, 32'h9000_07FC, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("r1_top_word_fault", 32'(flt), 32'd0);

    applyStimulus(1'b0, 4'hF, 32'h9000_0800, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("r1_past_limit_fault", 32'(flt), 32'd1);
    checkOutput("fault_count_5", 32'(fault_count), 32'd5);

    // Request held high: reads take four cycles, so three accepts in twelve
    req = 1'b1; we = 1'b0; byte_en = 4'hF; address = 32'h1001_0004;
    accepts = 0; rsps = 0;
    for (int k = 0; k < 12; k++) begin
      if (ready) accepts++;
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    req = 1'b0;
    checkOutput("held_req_accepts", 32'(accepts), 32'd3);
    checkOutput("held_req_responses", 32'(rsps), 32'd3);
    checkOutput("held_req_data", read_data, 32'hDEAD_BEEF);
    @(negedge clk);

    // Reset while a write is in ISSUE must suppress the write and its response
    req = 1'b1; we = 1'b1; byte_en = 4'hF; address = 32'h1001_0004; write_data = 32'h1234_5678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_issue", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_we", 32'(mem_we), 32'h0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_read_data", read_data, 32'd0);
    checkOutput("abort_fault_count", 32'(fault_count), 32'd0);
    rsps = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid) rsps++;
    end
    rst_n = 1'b1;
    checkOutput("abort_no_response", 32'(rsps), 32'd0);
    applyStimulus(1'b0, 4'hF, 32'h1001_0004, 32'h0, lat, rdata, flt, we_or, we_cycles, we_addr);
    checkOutput("abort_read_latency", 32'(lat), 32'd3);
    checkOutput("abort_old_data", rdata, 32'hDEAD_BEEF);

    // 300 back-to-back faults saturate the counter
    req = 1'b1; we = 1'b0; byte_en = 4'hF; address = 32'h0040_0000;
    n_rsp = 0; cnt254 = '0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n_rsp++;
        if (n_rsp == 254) cnt254 = fault_count;
        if (n_rsp == 300) begin
          req = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    checkOutput("sat_responses", 32'(n_rsp), 32'd300);
    checkOutput("sat_count_254", 32'(cnt254), 32'd254);
    checkOutput("sat_count_final", 32'(fault_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
